// File: rtl/fetch_ifid_unit.sv
// Instruction-fetch front end: PC generation, synchronous imem request,
// IF/ID register with a one-entry skid buffer for stall and flush handling.
module fetch_ifid_unit #(
    parameter int unsigned      ISIZE    = 32,
    parameter int unsigned      ASIZE    = 32,
    parameter int unsigned      PC_INC   = 1,
    parameter logic [ASIZE-1:0] RESET_PC = '0,
    parameter int unsigned      CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [ASIZE-1:0] redirect_pc,
    output logic [ASIZE-1:0] imem_addr,
    output logic             imem_en,
    input  logic [ISIZE-1:0] imem_rdata,
    output logic [ISIZE-1:0] id_inst,
    output logic [ASIZE-1:0] id_pc,
    output logic             id_valid,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [ASIZE-1:0] pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [ASIZE-1:0] inflight_pc_q, inflight_pc_d;
    logic             skid_valid_q, skid_valid_d;
    logic [ISIZE-1:0] skid_inst_q, skid_inst_d;
    logic [ASIZE-1:0] skid_pc_q, skid_pc_d;
    logic [ISIZE-1:0] id_inst_q, id_inst_d;
    logic [ASIZE-1:0] id_pc_q, id_pc_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic fetch_en;
    logic resp_live;

    assign fetch_en  = !stall && !flush && !rst;
    assign resp_live = inflight_q && !flush;

    assign imem_addr = pc_q;
    assign imem_en   = fetch_en;
    assign id_inst   = id_inst_q;
    assign id_pc     = id_pc_q;
    assign id_valid  = id_valid_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = fetch_en;
        inflight_pc_d = inflight_pc_q;
        if (flush) begin
            pc_d = redirect_pc;
        end else if (fetch_en) begin
            pc_d = pc_q + ASIZE'(PC_INC);
        end
        if (fetch_en) begin
            inflight_pc_d = pc_q;
        end
    end

    // Issue stops during stall, so the skid never holds more than the one
    // response that was already in flight when the stall began.
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        id_inst_d    = id_inst_q;
        id_pc_d      = id_pc_q;
        id_valid_d   = id_valid_q;
        if (flush) begin
            id_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (stall) begin
            if (resp_live) begin
                skid_valid_d = 1'b1;
                skid_inst_d  = imem_rdata;
                skid_pc_d    = inflight_pc_q;
            end
        end else if (skid_valid_q) begin
            id_inst_d    = skid_inst_q;
            id_pc_d      = skid_pc_q;
            id_valid_d   = 1'b1;
            skid_valid_d = 1'b0;
        end else if (resp_live) begin
            id_inst_d  = imem_rdata;
            id_pc_d    = inflight_pc_q;
            id_valid_d = 1'b1;
        end else begin
            id_valid_d = 1'b0;
        end
    end

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            skid_valid_q  <= 1'b0;
            skid_inst_q   <= '0;
            skid_pc_q     <= '0;
            id_inst_q     <= '0;
            id_pc_q       <= '0;
            id_valid_q    <= 1'b0;
            flush_cnt_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_inst_q   <= skid_inst_d;
            skid_pc_q     <= skid_pc_d;
            id_inst_q     <= id_inst_d;
            id_pc_q       <= id_pc_d;
            id_valid_q    <= id_valid_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_ifid_unit.sv
// Bench for fetch_ifid_unit: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, randomized stall/flush traffic.
module tb_fetch_ifid_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata = '0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [15:0] flush_cnt;

    logic        rst2 = 1'b1;
    logic [3:0]  imem_addr2;
    logic        imem_en2;
    logic [31:0] imem_rdata2 = '0;
    logic [31:0] id_inst2;
    logic [3:0]  id_pc2;
    logic        id_valid2;
    logic [15:0] flush_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_ifid_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_rdata(imem_rdata), .id_inst(id_inst), .id_pc(id_pc),
        .id_valid(id_valid), .flush_cnt(flush_cnt)
    );

    fetch_ifid_unit #(.ASIZE(4), .RESET_PC(4'd14), .PC_INC(1)) dut2 (
        .clk(clk), .rst(rst2), .stall(1'b0), .flush(1'b0),
        .redirect_pc(4'd0), .imem_addr(imem_addr2), .imem_en(imem_en2),
        .imem_rdata(imem_rdata2), .id_inst(id_inst2), .id_pc(id_pc2),
        .id_valid(id_valid2), .flush_cnt(flush_cnt2)
    );

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return 32'h1000 + a;
    endfunction

    always @(posedge clk) begin
        if (imem_en)  imem_rdata  <= mem_word(imem_addr);
        if (imem_en2) imem_rdata2 <= mem_word({28'h0, imem_addr2});
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetched-but-undelivered instructions live in a queue.
    logic [31:0] m_pc = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_idpc = '0;
    logic [31:0] pend[$];
    logic        m_iss_v = 1'b0;
    logic [31:0] m_iss_pc = '0;
    logic [15:0] m_fcnt = '0;
    logic        m_en;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = '0; m_valid = 1'b0; m_idpc = '0; pend.delete();
            m_iss_v = 1'b0; m_iss_pc = '0; m_fcnt = '0;
        end else begin
            m_en = !stall && !flush;
            if (flush) begin
                pend.delete();
                m_valid = 1'b0;
                if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
            end else begin
                if (m_iss_v) pend.push_back(m_iss_pc);
                if (!stall) begin
                    if (pend.size() > 0) begin
                        m_valid = 1'b1;
                        m_idpc  = pend.pop_front();
                    end else begin
                        m_valid = 1'b0;
                    end
                end
            end
            m_iss_v  = m_en;
            m_iss_pc = m_pc;
            if (flush)     m_pc = redirect_pc;
            else if (m_en) m_pc = m_pc + 32'd1;
        end
    end

    always @(negedge clk) begin
        chk("imem_en", imem_en, !stall && !flush && !rst);
        chk("imem_addr", imem_addr, m_pc);
        chk("id_valid", id_valid, m_valid);
        chk("flush_cnt", flush_cnt, m_fcnt);
        if (m_valid) begin
            chk("id_pc", id_pc, m_idpc);
            chk("id_inst", id_inst, mem_word(m_idpc));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idpc(input logic [31:0] pc);
        bit found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (id_valid && id_pc == pc) found = 1;
            else step();
        end
        chk("wait_idpc_timeout", found, 1'b1);
    endtask

    initial begin
        repeat (2) step();
        rst  = 1'b0;
        rst2 = 1'b0;

        step();
        chk("lat_c1_valid", id_valid, 1'b0);
        chk("lat_c1_addr", imem_addr, 32'd1);
        step();
        chk("lat_c2_valid", id_valid, 1'b1);
        chk("lat_c2_pc", id_pc, 32'd0);
        chk("lat_c2_inst", id_inst, 32'h1000);
        chk("wrap_pc0", id_pc2, 4'd14);
        chk("wrap_inst0", id_inst2, 32'h100E);
        step();
        chk("seq_pc1", id_pc, 32'd1);
        chk("wrap_pc1", id_pc2, 4'd15);
        step();
        chk("seq_pc2", id_pc, 32'd2);
        chk("wrap_pc2", id_pc2, 4'd0);
        chk("wrap_inst2", id_inst2, 32'h1000);
        step();
        chk("wrap_pc3", id_pc2, 4'd1);
        chk("wrap_valid3", id_valid2, 1'b1);

        wait_idpc(32'd5);
        stall = 1'b1;
        #1;
        chk("stall_imem_en", imem_en, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_pc", id_pc, 32'd5);
            chk("stall_hold_valid", id_valid, 1'b1);
        end
        stall = 1'b0;
        step();
        chk("unstall_pc6", id_pc, 32'd6);
        step();
        chk("unstall_pc7", id_pc, 32'd7);

        wait_idpc(32'd8);
        flush = 1'b1;
        redirect_pc = 32'h40;
        step();
        flush = 1'b0;
        chk("flush_bubble1", id_valid, 1'b0);
        chk("flush_cnt1", flush_cnt, 16'd1);
        chk("flush_issue", imem_addr, 32'h40);
        step();
        chk("flush_bubble2", id_valid, 1'b0);
        step();
        chk("redir_valid", id_valid, 1'b1);
        chk("redir_pc", id_pc, 32'h40);
        chk("redir_inst", id_inst, 32'h1040);
        step();
        chk("redir_next", id_pc, 32'h41);

        stall = 1'b1;
        step();
        flush = 1'b1;
        redirect_pc = 32'h80;
        step();
        flush = 1'b0;
        stall = 1'b0;
        begin
            bit got = 0;
            for (int k = 0; k < 6 && !got; k++) begin
                if (id_valid) got = 1;
                else step();
            end
            chk("fs_found", got, 1'b1);
            chk("fs_pc", id_pc, 32'h80);
        end

        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 11) == 0);
            redirect_pc = $urandom();
            step();
        end
        stall = 1'b0;
        flush = 1'b0;

        // Fill the skid, then pulse reset between clock edges.
        step();
        step();
        stall = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", id_valid, 1'b0);
        chk("ar_pc", id_pc, 32'd0);
        chk("ar_inst", id_inst, 32'd0);
        chk("ar_fcnt", flush_cnt, 16'd0);
        chk("ar_en", imem_en, 1'b0);
        chk("ar_addr", imem_addr, 32'd0);
        step();
        stall = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("rs_c1_valid", id_valid, 1'b0);
        step();
        chk("rs_c2_valid", id_valid, 1'b1);
        chk("rs_c2_pc", id_pc, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
